// File: rtl/tilemap_scroll_renderer.sv
// Tilemap layer renderer: screen (x, y) -> scrolled map position -> tile
// index/attribute read -> pixel word read -> extracted 1/2/4/8 bpp colour
// combined with the 4-bit palette from the tile attribute.
// Four-stage valid-tracked pipeline, one pixel per cycle, no backpressure.
// Optional feature macro: TILEMAP_FLIP_EN (tile_attr[6]/[7] flip x/y).
module tilemap_scroll_renderer #(
  parameter int X_BITS              = 10,
  parameter int Y_BITS              = 9,
  parameter int TILE_ADDR_X_BITS    = 6,
  parameter int TILE_ADDR_Y_BITS    = 5,
  parameter int TILE_INDEX_BITS     = 8,
  parameter int PIXEL_OFFSET_X_BITS = 3,
  parameter int PIXEL_OFFSET_Y_BITS = 3,
  parameter int PIXEL_BITS          = 8,
  parameter int SCALE_BITS          = 2,
  parameter int ATTR_BITS           = 8
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic [SCALE_BITS-1:0]                         x_shift,
  input  logic [SCALE_BITS-1:0]                         y_shift,
  input  logic [1:0]                                    bpp_log2,
  input  logic [X_BITS-1:0]                             scroll_x,
  input  logic [Y_BITS-1:0]                             scroll_y,
  input  logic                                          line_start,
  input  logic                                          in_valid,
  input  logic [X_BITS-1:0]                             x_in,
  input  logic [Y_BITS-1:0]                             y_in,
  output logic                                          tilemap_en,
  output logic [TILE_ADDR_Y_BITS+TILE_ADDR_X_BITS-1:0]  tilemap_addr,
  input  logic [TILE_INDEX_BITS-1:0]                    tile_index,
  input  logic [ATTR_BITS-1:0]                          tile_attr,
  output logic                                          pixel_en,
  output logic [TILE_INDEX_BITS+PIXEL_OFFSET_X_BITS+PIXEL_OFFSET_Y_BITS-1:0] pixel_addr,
  input  logic [PIXEL_BITS-1:0]                         pixel_data,
  output logic                                          out_valid,
  output logic [PIXEL_BITS-1:0]                         pixel_out,
  output logic                                          transparent
);

  localparam int PIX_ADDR_W = TILE_INDEX_BITS + PIXEL_OFFSET_X_BITS + PIXEL_OFFSET_Y_BITS;
  localparam int BIT_ADDR_W = PIX_ADDR_W + 3;
  localparam int WIDE_W     = PIXEL_BITS + 8;

  // Colour value of bpp bits starting at bit offset frac within the word.
  function automatic logic [PIXEL_BITS-1:0] extract_value(
    input logic [PIXEL_BITS-1:0] data,
    input logic [2:0]            frac,
    input logic [1:0]            bl
  );
    logic [WIDE_W-1:0] mask;
    logic [WIDE_W-1:0] shifted;
    mask    = (WIDE_W'(1) << (4'd1 << bl)) - WIDE_W'(1);
    shifted = WIDE_W'(data) >> frac;
    return PIXEL_BITS'(shifted & mask);
  endfunction

  // Palette in the bits above the colour value, truncated to the output width.
  function automatic logic [PIXEL_BITS-1:0] compose_pixel(
    input logic [3:0]            pal,
    input logic [PIXEL_BITS-1:0] value,
    input logic [1:0]            bl
  );
    logic [WIDE_W-1:0] wide;
    wide = (WIDE_W'(pal) << (4'd1 << bl)) | WIDE_W'(value);
    return PIXEL_BITS'(wide);
  endfunction

  logic [X_BITS-1:0] scroll_x_q, scroll_x_d;
  logic [Y_BITS-1:0] scroll_y_q, scroll_y_d;
  logic [X_BITS-1:0] x_p0;
  logic [Y_BITS-1:0] y_p0;

  logic vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d, vld_p3_q, vld_p3_d;
  logic out_valid_q, out_valid_d;
  logic [PIXEL_BITS-1:0] pixel_out_q, pixel_out_d;
  logic transparent_q, transparent_d;

  logic [PIXEL_OFFSET_X_BITS-1:0] pixel_x_p1_q, pixel_x_p1_d, px_p1;
  logic [PIXEL_OFFSET_Y_BITS-1:0] pixel_y_p1_q, pixel_y_p1_d, py_p1;
  logic [BIT_ADDR_W-1:0]          bit_addr_p2_q, bit_addr_p2_d;
  logic [3:0]                     pal_p2_q, pal_p2_d, pal_p3_q, pal_p3_d;
  logic [2:0]                     frac_p3_q, frac_p3_d;
  logic [PIXEL_BITS-1:0]          value_p3;

  logic unused_bits;
  assign unused_bits = ^{x_p0, y_p0, tile_attr};

  // Stage 0: scrolled coordinate, tile map address, scroll latch
  always_comb begin
    scroll_x_d   = line_start ? scroll_x : scroll_x_q;
    scroll_y_d   = line_start ? scroll_y : scroll_y_q;
    x_p0         = (x_in >> x_shift) + scroll_x_q;
    y_p0         = (y_in >> y_shift) + scroll_y_q;
    tilemap_en   = in_valid;
    tilemap_addr = {y_p0[PIXEL_OFFSET_Y_BITS+TILE_ADDR_Y_BITS-1:PIXEL_OFFSET_Y_BITS],
                    x_p0[PIXEL_OFFSET_X_BITS+TILE_ADDR_X_BITS-1:PIXEL_OFFSET_X_BITS]};
    vld_p1_d     = in_valid;
    pixel_x_p1_d = in_valid ? x_p0[PIXEL_OFFSET_X_BITS-1:0] : pixel_x_p1_q;
    pixel_y_p1_d = in_valid ? y_p0[PIXEL_OFFSET_Y_BITS-1:0] : pixel_y_p1_q;
  end

  // Stage 1: optional flip, bit address of the pixel inside pixel memory
  always_comb begin
`ifdef TILEMAP_FLIP_EN
    px_p1 = tile_attr[6] ? ~pixel_x_p1_q : pixel_x_p1_q;
    py_p1 = tile_attr[7] ? ~pixel_y_p1_q : pixel_y_p1_q;
`else
    px_p1 = pixel_x_p1_q;
    py_p1 = pixel_y_p1_q;
`endif
    vld_p2_d      = vld_p1_q;
    bit_addr_p2_d = vld_p1_q ? (BIT_ADDR_W'({tile_index, py_p1, px_p1}) << bpp_log2)
                             : bit_addr_p2_q;
    pal_p2_d      = vld_p1_q ? tile_attr[3:0] : pal_p2_q;
  end

  // Stage 2: pixel word read, keep bit offset for extraction
  always_comb begin
    pixel_en   = vld_p2_q;
    pixel_addr = bit_addr_p2_q[BIT_ADDR_W-1:3];
    vld_p3_d   = vld_p2_q;
    frac_p3_d  = vld_p2_q ? bit_addr_p2_q[2:0] : frac_p3_q;
    pal_p3_d   = vld_p2_q ? pal_p2_q : pal_p3_q;
  end

  // Stage 3: extract colour value, merge palette, flag transparency
  always_comb begin
    value_p3      = extract_value(pixel_data, frac_p3_q, bpp_log2);
    out_valid_d   = vld_p3_q;
    pixel_out_d   = pixel_out_q;
    transparent_d = transparent_q;
    if (vld_p3_q) begin
      pixel_out_d   = compose_pixel(pal_p3_q, value_p3, bpp_log2);
      transparent_d = (value_p3 == '0);
    end
  end

  // Control state: valid chain, outputs and scroll latch, cleared on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      scroll_x_q    <= '0;
      scroll_y_q    <= '0;
      vld_p1_q      <= 1'b0;
      vld_p2_q      <= 1'b0;
      vld_p3_q      <= 1'b0;
      out_valid_q   <= 1'b0;
      pixel_out_q   <= '0;
      transparent_q <= 1'b0;
    end else begin
      scroll_x_q    <= scroll_x_d;
      scroll_y_q    <= scroll_y_d;
      vld_p1_q      <= vld_p1_d;
      vld_p2_q      <= vld_p2_d;
      vld_p3_q      <= vld_p3_d;
      out_valid_q   <= out_valid_d;
      pixel_out_q   <= pixel_out_d;
      transparent_q <= transparent_d;
    end
  end

  // Datapath registers: no reset, hold when their stage is idle
  always_ff @(posedge clk) begin
    pixel_x_p1_q  <= pixel_x_p1_d;
    pixel_y_p1_q  <= pixel_y_p1_d;
    bit_addr_p2_q <= bit_addr_p2_d;
    pal_p2_q      <= pal_p2_d;
    frac_p3_q     <= frac_p3_d;
    pal_p3_q      <= pal_p3_d;
  end

  assign out_valid   = out_valid_q;
  assign pixel_out   = pixel_out_q;
  assign transparent = transparent_q;

endmodule

// File: tb/tb_tilemap_scroll_renderer.sv
// Directed testbench for tilemap_scroll_renderer: table of single-pixel
// vectors plus hand sequences for scroll latching, bursts and reset.
// Expectations for flipped tiles follow the TILEMAP_FLIP_EN macro.
module tb_tilemap_scroll_renderer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  x_shift, y_shift, bpp_log2;
  logic [9:0]  scroll_x, x_in;
  logic [8:0]  scroll_y, y_in;
  logic        line_start, in_valid;
  logic        tilemap_en, pixel_en, out_valid, transparent;
  logic [10:0] tilemap_addr;
  logic [7:0]  tile_index, tile_attr, pixel_data, pixel_out;
  logic [13:0] pixel_addr;

  int checks = 0;
  int errors = 0;

  tilemap_scroll_renderer dut (
    .clk(clk), .reset(reset), .x_shift(x_shift), .y_shift(y_shift),
    .bpp_log2(bpp_log2), .scroll_x(scroll_x), .scroll_y(scroll_y),
    .line_start(line_start), .in_valid(in_valid), .x_in(x_in), .y_in(y_in),
    .tilemap_en(tilemap_en), .tilemap_addr(tilemap_addr),
    .tile_index(tile_index), .tile_attr(tile_attr),
    .pixel_en(pixel_en), .pixel_addr(pixel_addr), .pixel_data(pixel_data),
    .out_valid(out_valid), .pixel_out(pixel_out), .transparent(transparent)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  xi;
    logic [8:0]  yi;
    logic [1:0]  xs, ys, bl;
    logic [9:0]  sx;
    logic [8:0]  sy;
    logic [7:0]  ti, attr, pd;
    logic [10:0] map;
    logic [13:0] paddr;
    logic [7:0]  pout;
    logic        tr;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  bit pat[18] = '{1,1,1,1,1,1,1,1,0,0,1,1,1,0,0,0,0,0};

  initial begin
    //          xi     yi    xs ys bl  sx     sy    ti     attr    pd      map     paddr   pout    tr
    vecs[0] = '{10'd0, 9'd0, 0, 0, 0, 10'd0, 9'd0, 8'd0, 8'h00, 8'h00, 11'd0,  14'd0,   8'h00, 1'b1};
    vecs[1] = '{10'd5, 9'd3, 0, 0, 3, 10'd16, 9'd8, 8'd1, 8'h03, 8'h7E, 11'd66, 14'd93,  8'h7E, 1'b0};
    vecs[2] = '{10'd1023, 9'd0, 0, 0, 1, 10'd2, 9'd0, 8'd2, 8'h02, 8'hC0, 11'd0, 14'd32, 8'h08, 1'b1};
    vecs[3] = '{10'd20, 9'd0, 1, 0, 0, 10'd0, 9'd0, 8'd0, 8'h01, 8'h04, 11'd1,  14'd0,   8'h03, 1'b0};
    vecs[4] = '{10'd3, 9'd1, 0, 0, 2, 10'd0, 9'd0, 8'd3, 8'h05, 8'hA5, 11'd0,  14'd101, 8'h5A, 1'b0};
`ifdef TILEMAP_FLIP_EN
    vecs[5] = '{10'd3, 9'd1, 0, 0, 2, 10'd0, 9'd0, 8'd3, 8'h45, 8'hA5, 11'd0,  14'd102, 8'h55, 1'b0};
    vecs[6] = '{10'd3, 9'd2, 0, 1, 2, 10'd0, 9'd0, 8'd3, 8'h85, 8'hA5, 11'd0,  14'd121, 8'h5A, 1'b0};
`else
    vecs[5] = '{10'd3, 9'd1, 0, 0, 2, 10'd0, 9'd0, 8'd3, 8'h45, 8'hA5, 11'd0,  14'd101, 8'h5A, 1'b0};
    vecs[6] = '{10'd3, 9'd2, 0, 1, 2, 10'd0, 9'd0, 8'd3, 8'h85, 8'hA5, 11'd0,  14'd101, 8'h5A, 1'b0};
`endif
    vecs[7] = '{10'd3, 9'd1, 0, 0, 2, 10'd0, 9'd0, 8'd3, 8'h07, 8'h0F, 11'd0,  14'd101, 8'h70, 1'b1};

    reset = 1'b1; x_shift = 0; y_shift = 0; bpp_log2 = 0; scroll_x = 0; scroll_y = 0;
    line_start = 0; in_valid = 0; x_in = 0; y_in = 0;
    tile_index = 0; tile_attr = 0; pixel_data = 0;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_pixel_out", pixel_out, 0);
    chk("reset_transparent", transparent, 0);
    chk("reset_pixel_en", pixel_en, 0);
    chk("reset_tilemap_en", tilemap_en, 0);
    tick();

    // Table-driven single-pixel vectors
    for (int i = 0; i < 8; i++) begin
      line_start = 1; scroll_x = vecs[i].sx; scroll_y = vecs[i].sy;
      x_shift = vecs[i].xs; y_shift = vecs[i].ys; bpp_log2 = vecs[i].bl;
      tick();
      line_start = 0;
      in_valid = 1; x_in = vecs[i].xi; y_in = vecs[i].yi;
      tile_index = vecs[i].ti; tile_attr = vecs[i].attr; pixel_data = vecs[i].pd;
      #1;
      chk($sformatf("v%0d_tilemap_en", i), tilemap_en, 1);
      chk($sformatf("v%0d_tilemap_addr", i), tilemap_addr, vecs[i].map);
      tick();
      in_valid = 0;
      #1;
      chk($sformatf("v%0d_out_valid_t1", i), out_valid, 0);
      tick();
      chk($sformatf("v%0d_pixel_en", i), pixel_en, 1);
      chk($sformatf("v%0d_pixel_addr", i), pixel_addr, vecs[i].paddr);
      tick();
      chk($sformatf("v%0d_out_valid_t3", i), out_valid, 0);
      tick();
      chk($sformatf("v%0d_out_valid_t4", i), out_valid, 1);
      chk($sformatf("v%0d_pixel_out", i), pixel_out, vecs[i].pout);
      chk($sformatf("v%0d_transparent", i), transparent, vecs[i].tr);
      tick();
      chk($sformatf("v%0d_out_valid_t5", i), out_valid, 0);
    end

    // Scroll only changes on line_start; same-cycle line_start uses old scroll
    x_shift = 0; y_shift = 0;
    line_start = 1; scroll_x = 16; scroll_y = 8;
    tick();
    line_start = 0; scroll_x = 100; scroll_y = 50;
    in_valid = 1; x_in = 5; y_in = 3;
    #1;
    chk("scroll_ignored_midline", tilemap_addr, 11'd66);
    tick();
    line_start = 1; scroll_x = 0; scroll_y = 0;
    #1;
    chk("scroll_same_cycle_old", tilemap_addr, 11'd66);
    tick();
    line_start = 0;
    #1;
    chk("scroll_new_applied", tilemap_addr, 11'd0);
    tick();
    in_valid = 0;
    for (int k = 0; k < 6; k++) tick();

    // Burst with a gap: out_valid repeats the in_valid pattern 4 cycles later
    for (int k = 0; k < 18; k++) begin
      in_valid = pat[k]; x_in = 10'(k);
      #1;
      chk($sformatf("burst_tilemap_en_%0d", k), tilemap_en, pat[k]);
      chk($sformatf("burst_out_valid_%0d", k), out_valid, (k >= 4) ? pat[k-4] : 1'b0);
      tick();
    end

    // Reset after two inputs discards them
    in_valid = 1;
    tick(); tick();
    in_valid = 0; reset = 1;
    tick();
    reset = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("midreset_out_valid_%0d", k), out_valid, 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
